// File: rtl/median_window_3x3.sv
// median_window_3x3
// Buffers two raster lines and emits one 3x3 neighbourhood per interior pixel
// on an AXI4-Stream master with a single output register (latency 1).
// Window packing: pixel (r,c) at [DATA_W*(3*r+c) +: DATA_W], r=0 oldest line,
// c=0 oldest column.
module median_window_3x3 #(
    parameter int DATA_W     = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tlast,
    output logic [9*DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              err_eol
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    // Position counters and their effective value for the pixel being accepted
    logic [COL_W-1:0] col_q, col_d, eff_col_s;
    logic [ROW_W-1:0] row_q, row_d, eff_row_s;

    // Two line buffers: lb1 holds the older line, lb0 the newer one
    logic [DATA_W-1:0] lb0_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb0_rd_s, lb1_rd_s;

    // Window register, indexed [column][row]
    logic [DATA_W-1:0] win_q [3][3];
    logic [DATA_W-1:0] win_d [3][3];

    logic m_valid_q, m_valid_d;
    logic m_user_q,  m_user_d;
    logic m_last_q,  m_last_d;
    logic err_q,     err_d;

    logic accept_s, at_end_s, emit_s;

    // Input can be taken whenever the single output slot is free or being drained
    assign s_axis_tready = !ARESET && (!m_valid_q || m_axis_tready);
    assign accept_s      = s_axis_tvalid && s_axis_tready;

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tlast  = m_last_q;
    assign err_eol       = err_q;

    for (genvar gr = 0; gr < 3; gr++) begin : g_row
        for (genvar gc = 0; gc < 3; gc++) begin : g_col
            assign m_axis_tdata[DATA_W*(3*gr+gc) +: DATA_W] = win_q[gc][gr];
        end
    end

    // Next-state logic: SOF forcing, counters, window shift and output slot
    always_comb begin
        eff_col_s = s_axis_tuser ? {COL_W{1'b0}} : col_q;
        eff_row_s = s_axis_tuser ? {ROW_W{1'b0}} : row_q;
        lb0_rd_s  = lb0_q[eff_col_s];
        lb1_rd_s  = lb1_q[eff_col_s];
        at_end_s  = (eff_col_s == COL_LAST);
        emit_s    = (eff_row_s >= ROW_TWO) && (eff_col_s >= COL_TWO);

        col_d     = col_q;
        row_d     = row_q;
        win_d     = win_q;
        m_valid_d = m_valid_q;
        m_user_d  = m_user_q;
        m_last_d  = m_last_q;
        err_d     = err_q;

        if (accept_s) begin
            win_d[0]    = win_q[1];
            win_d[1]    = win_q[2];
            win_d[2][0] = lb1_rd_s;
            win_d[2][1] = lb0_rd_s;
            win_d[2][2] = s_axis_tdata;

            // An early tlast closes the line just like the last column does
            if (s_axis_tlast || at_end_s) begin
                col_d = {COL_W{1'b0}};
                row_d = (eff_row_s == ROW_LAST) ? {ROW_W{1'b0}} : eff_row_s + ROW_W'(1);
            end else begin
                col_d = eff_col_s + COL_W'(1);
                row_d = eff_row_s;
            end

            if (s_axis_tlast != at_end_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end

            m_valid_d = emit_s;
            m_user_d  = emit_s && (eff_row_s == ROW_TWO) && (eff_col_s == COL_TWO);
            m_last_d  = emit_s && at_end_s;
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
            m_user_d  = 1'b0;
            m_last_d  = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Control and window registers with synchronous reset
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            col_q     <= {COL_W{1'b0}};
            row_q     <= {ROW_W{1'b0}};
            m_valid_q <= 1'b0;
            m_user_q  <= 1'b0;
            m_last_q  <= 1'b0;
            err_q     <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[c][r] <= {DATA_W{1'b0}};
                end
            end
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            m_valid_q <= m_valid_d;
            m_user_q  <= m_user_d;
            m_last_q  <= m_last_d;
            err_q     <= err_d;
            win_q     <= win_d;
        end
    end

    // Line buffers age by one line at the accepted column (contents not reset)
    always_ff @(posedge ACLK) begin
        if (accept_s) begin
            lb1_q[eff_col_s] <= lb0_rd_s;
            lb0_q[eff_col_s] <= s_axis_tdata;
        end
    end

endmodule

// File: tb/tb_median_window_3x3.sv
// Bench for median_window_3x3 on a 4x4 image: a window-level reference model
// (per-column pixel history plus position tracking) predicts every output.
module tb_median_window_3x3;

    localparam int W = 4;
    localparam int H = 4;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [7:0]  s_axis_tdata = 8'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [71:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        err_eol;

    median_window_3x3 #(.DATA_W(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .err_eol(err_eol)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;

    // reference model state
    int         mcol, mrow;
    logic       merr;
    logic [7:0] hv [W][3];
    logic       hk [W][3];
    logic [71:0] q_data [$];
    logic [71:0] q_mask [$];
    logic        q_user [$];
    logic        q_last [$];

    // observation state
    logic        held_v;
    logic [71:0] held_d;
    logic        held_u, held_l;
    logic        tog;
    int          n_win, n_user, n_last;
    logic [71:0] first_win, last_win;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int base);
        logic [71:0] v;
        v = 72'd0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[8*(3*r+c) +: 8] = 8'(base + 4*r + c);
        return v;
    endfunction

    task automatic model_reset();
        mcol = 0; mrow = 0; merr = 1'b0;
        for (int c = 0; c < W; c++)
            for (int r = 0; r < 3; r++) begin
                hv[c][r] = 8'd0;
                hk[c][r] = 1'b0;
            end
        q_data.delete(); q_mask.delete(); q_user.delete(); q_last.delete();
        held_v = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] d, input logic u, input logic l);
        int ec, er;
        logic is_end;
        logic [71:0] wd, wm;
        ec = u ? 0 : mcol;
        er = u ? 0 : mrow;
        hv[ec][0] = hv[ec][1]; hk[ec][0] = hk[ec][1];
        hv[ec][1] = hv[ec][2]; hk[ec][1] = hk[ec][2];
        hv[ec][2] = d;         hk[ec][2] = 1'b1;
        if (er >= 2 && ec >= 2) begin
            wd = 72'd0; wm = 72'd0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    wd[8*(3*r+c) +: 8] = hv[ec-2+c][r];
                    wm[8*(3*r+c) +: 8] = hk[ec-2+c][r] ? 8'hFF : 8'h00;
                end
            q_data.push_back(wd);
            q_mask.push_back(wm);
            q_user.push_back(er == 2 && ec == 2);
            q_last.push_back(ec == W-1);
        end
        is_end = (ec == W-1);
        if (l || is_end) begin
            mcol = 0;
            mrow = (er + 1) % H;
        end else begin
            mcol = ec + 1;
            mrow = er;
        end
        if (l != is_end) merr = 1'b1;
    endtask

    // one clock cycle: drive, check outputs against the model, update the model
    task automatic cyc(input logic v, input logic [7:0] d, input logic u, input logic l,
                       input logic mr, output logic acc);
        logic take;
        @(negedge ACLK);
        s_axis_tvalid = v; s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l;
        m_axis_tready = mr;
        #1;
        if (held_v) begin
            chk("stall_data", m_axis_tdata, held_d);
            chk("stall_user_last", {m_axis_tuser, m_axis_tlast}, {held_u, held_l});
        end
        chk("m_tvalid", m_axis_tvalid, q_data.size() != 0);
        chk("s_tready", s_axis_tready, (q_data.size() == 0) || mr);
        chk("err_eol", err_eol, merr);
        take = m_axis_tvalid && mr;
        if (take) begin
            if (q_data.size() == 0) begin
                chk("extra_window", 1'b1, 1'b0);
            end else begin
                chk("win_data", m_axis_tdata & q_mask[0], q_data[0] & q_mask[0]);
                chk("win_user", m_axis_tuser, q_user[0]);
                chk("win_last", m_axis_tlast, q_last[0]);
                void'(q_data.pop_front()); void'(q_mask.pop_front());
                void'(q_user.pop_front()); void'(q_last.pop_front());
            end
            n_win++;
            if (m_axis_tuser) begin n_user++; first_win = m_axis_tdata; end
            if (m_axis_tlast) n_last++;
            last_win = m_axis_tdata;
        end
        held_v = m_axis_tvalid && !mr;
        held_d = m_axis_tdata; held_u = m_axis_tuser; held_l = m_axis_tlast;
        acc = v && s_axis_tready;
        if (acc) model_accept(d, u, l);
    endtask

    // mode: 0 ready=1, 1 toggling 1010, 2 random, 3 ready=0
    task automatic send_pixel(input logic [7:0] d, input logic u, input logic l,
                              input int mode, input logic vr);
        logic acc, mr, v;
        acc = 1'b0;
        for (int i = 0; i < 64 && !acc; i++) begin
            case (mode)
                0:       mr = 1'b1;
                1:       begin mr = tog; tog = !tog; end
                2:       mr = 1'($urandom_range(0, 1));
                default: mr = 1'b0;
            endcase
            v = vr ? ($urandom_range(0, 3) != 0) : 1'b1;
            cyc(v, d, u, l, mr, acc);
        end
        if (!acc) chk("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_frame(input int base, input logic rnd, input int mode, input logic vr);
        logic [7:0] d;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                d = rnd ? 8'($urandom) : 8'(base + 4*r + c);
                send_pixel(d, (r == 0 && c == 0), (c == W-1), mode, vr);
            end
    endtask

    task automatic drain();
        logic acc;
        repeat (4) cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, acc);
        chk("drain_empty", 72'(q_data.size()), 72'd0);
    endtask

    task automatic clr_stats();
        n_win = 0; n_user = 0; n_last = 0;
        first_win = 72'd0; last_win = 72'd0;
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESET = 1'b1; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        chk("reset_s_tready", s_axis_tready, 1'b0);
        @(posedge ACLK);
        #1;
        chk("reset_m_tvalid", m_axis_tvalid, 1'b0);
        chk("reset_err_eol", err_eol, 1'b0);
        chk("reset_tdata", m_axis_tdata, 72'd0);
        chk("reset_user_last", {m_axis_tuser, m_axis_tlast}, 2'b00);
        model_reset();
        @(negedge ACLK);
        ARESET = 1'b0;
    endtask

    initial begin
        tog = 1'b1;
        model_reset();
        clr_stats();
        do_reset();

        // 1: clean 4x4 frame p=4r+c, downstream always ready
        clr_stats();
        send_frame(0, 1'b0, 0, 1'b0);
        drain();
        chk("t1_count", 72'(n_win), 72'd4);
        chk("t1_tuser_count", 72'(n_user), 72'd1);
        chk("t1_tlast_count", 72'(n_last), 72'd2);
        chk("t1_first", first_win, exp_win(0));
        chk("t1_last", last_win, exp_win(5));

        // 2: same frame with 1010 backpressure and random source valid
        clr_stats();
        send_frame(0, 1'b0, 1, 1'b1);
        drain();
        chk("t2_count", 72'(n_win), 72'd4);
        chk("t2_first", first_win, exp_win(0));
        chk("t2_last", last_win, exp_win(5));

        // 3: two back-to-back frames
        clr_stats();
        send_frame(0, 1'b0, 0, 1'b0);
        send_frame(100, 1'b0, 0, 1'b0);
        drain();
        chk("t3_count", 72'(n_win), 72'd8);
        chk("t3_first_f2", first_win, exp_win(100));
        chk("t3_last_f2", last_win, exp_win(105));

        // random data frames under random backpressure
        clr_stats();
        repeat (3) send_frame(0, 1'b1, 2, 1'b1);
        drain();
        chk("rand_count", 72'(n_win), 72'd12);

        // 4: early tlast at column 1 of row 0
        clr_stats();
        send_pixel(8'd30, 1'b1, 1'b0, 0, 1'b0);
        send_pixel(8'd31, 1'b0, 1'b1, 0, 1'b0);
        for (int r = 1; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pixel(8'(32 + 4*r + c), 1'b0, (c == W-1), 2, 1'b0);
        drain();
        chk("t4_err_sticky", err_eol, 1'b1);
        chk("t4_count", 72'(n_win), 72'd4);
        chk("t4_tuser_count", 72'(n_user), 72'd1);

        // 5: SOF arrives at pixel (2,1) of a partial frame
        clr_stats();
        for (int i = 0; i < 2*W + 1; i++)
            send_pixel(8'(20 + i), (i == 0), ((i % W) == W-1), 0, 1'b0);
        drain();
        chk("t5_no_window_before_sof", 72'(n_win), 72'd0);
        send_frame(60, 1'b0, 0, 1'b0);
        drain();
        chk("t5_count", 72'(n_win), 72'd4);
        chk("t5_first", first_win, exp_win(60));

        // 6: reset while a window is held, then a clean frame
        for (int i = 0; i < 2*W + 3; i++)
            send_pixel(8'(50 + i), (i == 0), ((i % W) == W-1), 3, 1'b0);
        @(negedge ACLK);
        m_axis_tready = 1'b0;
        #1;
        chk("t6_pre_reset_valid", m_axis_tvalid, 1'b1);
        chk("t6_pre_reset_err", err_eol, 1'b1);
        do_reset();
        clr_stats();
        send_frame(0, 1'b0, 0, 1'b0);
        drain();
        chk("t6_count", 72'(n_win), 72'd4);
        chk("t6_first", first_win, exp_win(0));
        chk("t6_last", last_win, exp_win(5));
        chk("t6_err_clear", err_eol, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
